// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared widths, FSM states and result helpers for the perceptron predictor.
package perceptron_pkg;
  localparam int WEIGHT_W = 8;
  localparam int BHR_W = 8;
  localparam int PT_IDX_W = 6;
  localparam int THRESHOLD = (193 * BHR_W) / 100 + 14;
  function automatic int acc_w(input int ww, input int bw);
    return ww + $clog2(bw + 2);
  endfunction
  localparam int ACC_W = acc_w(WEIGHT_W, BHR_W);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [WEIGHT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] smax, smin;
    smax = ACC_W'(2 ** (WEIGHT_W - 1) - 1);
    smin = -smax - 1'sb1;
    return v > smax ? smax[WEIGHT_W-1:0] : v < smin ? smin[WEIGHT_W-1:0] : v[WEIGHT_W-1:0];
  endfunction
endpackage

// File: rtl/perceptron_term_sum.sv
// perceptron_term_sum: signed sum of LANES weights, each negated when its history bit is 0.
module perceptron_term_sum
  import perceptron_pkg::*;
#(
  parameter int LANES = 3
) (
  input  logic [LANES*WEIGHT_W-1:0] w,
  input  logic [LANES-1:0]          x,
  input  logic [LANES-1:0]          vld,
  output logic signed [ACC_W-1:0]   sum
);
  logic signed [ACC_W-1:0] term [LANES];
  for (genvar i = 0; i < LANES; i++) begin : g_term
    logic signed [ACC_W-1:0] ext;
    // widening before negation keeps -(-2^(W-1)) exact
    assign ext = ACC_W'($signed(w[i*WEIGHT_W +: WEIGHT_W]));
    assign term[i] = !vld[i] ? '0 : x[i] ? ext : -ext;
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + term[i];
  end
endmodule

// File: rtl/perceptron_predict.sv
// perceptron_predict: serial perceptron dot product, LANES terms per cycle.
// Define PERCEPTRON_SAT_EN to saturate y_out_o instead of wrapping it.
module perceptron_predict
  import perceptron_pkg::*;
#(
  parameter int LANES = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pred_req_i,
  input  logic [63:0]                   pred_PC_i,
  input  logic [BHR_W-1:0]              BHR_i,
  output logic [PT_IDX_W-1:0]           pt_rd_idx_o,
  input  logic [(BHR_W+1)*WEIGHT_W-1:0] pt_weight_i,
  input  logic                          flush_i,
  output logic                          pred_busy_o,
  output logic                          y_vld_o,
  output logic [WEIGHT_W-1:0]           y_out_o,
  output logic                          pred_taken_o,
  output logic [63:0]                   pred_PC_o
);
  localparam int NT = BHR_W + 1;
  localparam int N = (NT + LANES - 1) / LANES;
  localparam int NP = N * LANES;
  localparam int SW = LANES * WEIGHT_W;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  localparam logic [NP-1:0] VMASK = {NP{1'b1}} >> (NP - NT);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic signed [ACC_W-1:0] acc, part, acc_nxt;
  logic [NP*WEIGHT_W-1:0] w_r;
  logic [NP-1:0] x_r;
  logic [63:0] pc_r;
  logic start, last;
  assign pt_rd_idx_o = pred_PC_i[PT_IDX_W-1:0];
  assign pred_busy_o = state == ACCUM;
  assign y_vld_o = state == DONE;
  assign start = state != ACCUM && pred_req_i && !flush_i;
  assign last = state == ACCUM && cnt == CNT_W'(N - 1);
  assign acc_nxt = acc + part;
  perceptron_term_sum #(.LANES(LANES)) u_sum (
    .w  (w_r[cnt*SW +: SW]),
    .x  (x_r[cnt*LANES +: LANES]),
    .vld(VMASK[cnt*LANES +: LANES]),
    .sum(part)
  );
  always_comb begin
    nxt = flush_i ? IDLE : start ? ACCUM : state != ACCUM ? IDLE : last ? DONE : ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      w_r <= '0;
      x_r <= '0;
      pc_r <= '0;
      y_out_o <= '0;
      pred_taken_o <= 1'b0;
      pred_PC_o <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
      w_r <= (NP*WEIGHT_W)'(pt_weight_i);
      x_r <= NP'({1'b1, BHR_i});
      pc_r <= pred_PC_i;
    end else if (state == ACCUM && !flush_i) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
`ifdef PERCEPTRON_SAT_EN
        y_out_o <= saturate(acc_nxt);
`else
        y_out_o <= acc_nxt[WEIGHT_W-1:0];
`endif
        pred_taken_o <= !acc_nxt[ACC_W-1];
        pred_PC_o <= pc_r;
      end
    end
  end
endmodule
